mcpu_ctrl: RTL and testbench

//  Multi-cycle control FSM that sequences the MIPS datapath (Regs, ALU, PC, IR/MDR, memory port).
//  It replaces the one-cycle decoder and drives per-state control strobes from the IR opcode/funct.
//  It stalls on the MIO_ready memory handshake and traps to a sticky error state on memory timeout.

---
 rtl/mcpu_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
// ---------------------------------------------------------------------------
// mcpu_ctrl -- multi-cycle MIPS control FSM
//
// Purpose:
//   Sequences the multi-cycle datapath (register file, ALU, PC, IR/MDR and
//   memory port) one state per cycle. The strobes are decoded from the state
//   register and the IR opcode/funct fields. The FSM stalls on the MIO_ready
//   handshake. If a memory state waits more than MEM_TIMEOUT cycles, the FSM
//   traps to a sticky ERR state. Only reset leaves ERR.
//
// Parameters:
//   MEM_TIMEOUT  largest wait count tolerated in IF/MRD/MWR (1..255)
//   INT_VECTOR   interrupt handler address (INT_HANDLER_EN builds only)
//
// Ports:
//   clk, rst             core clock; asynchronous active-low reset
//   Inst                 IR contents, valid from ID onward
//   zero                 ALU zero flag (the datapath applies it to PCWriteCond)
//   MIO_ready            memory handshake; a transfer completes when it is 1
//   INT                  level interrupt request (INT_HANDLER_EN builds only)
//   PCWrite..sign        datapath control strobes
//   state                current state code, for debug
//   mem_err              sticky memory-timeout flag
//   epc, int_ack, EPCWrite, int_vector
//                        interrupt extension ports (INT_HANDLER_EN builds only)
//
// Configuration macro:
//   INT_HANDLER_EN  adds the INT state and the interrupt/eret support.
//
// The strobes are a decode of the registered state and are not registered
// themselves. In IF, IRWrite and PCWrite must follow MIO_ready in the same
// cycle, and an asynchronous reset must drop every strobe at once. A decode
// of state_r meets both requirements.
// ---------------------------------------------------------------------------
module mcpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 32'd15
`ifdef INT_HANDLER_EN
  ,
  parameter logic [31:0] INT_VECTOR  = 32'h0000_0004
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        MIO_ready,
  input  logic        INT,
`ifdef INT_HANDLER_EN
  input  logic [31:0] epc,
  output logic        int_ack,
  output logic        EPCWrite,
  output logic [31:0] int_vector,
`endif
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch_ne,
  output logic [1:0]  PCSource,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALU_Control,
  output logic        sign,
  output logic [3:0]  state,
  output logic        mem_err
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,  S_IF  = 4'd1,  S_ID  = 4'd2,  S_EXR = 4'd3,
    S_EXI  = 4'd4,  S_WBA = 4'd5,  S_MADR = 4'd6, S_MRD = 4'd7,
    S_WBM  = 4'd8,  S_MWR = 4'd9,  S_BR  = 4'd10, S_JMP = 4'd11,
    S_JR   = 4'd12, S_LUI = 4'd13, S_ERR = 4'd14, S_INT = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
`ifdef INT_HANDLER_EN
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] FN_ERET  = 6'b011000;
`endif

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  state_t      state_r;
  state_t      next_s;
  state_t      id_next_s;
  state_t      done_next_s;
  logic [7:0]  cnt_r;
  logic        mem_err_r;
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic        r_alu_ok_s;
  logic [2:0]  r_alu_s;
  logic [2:0]  i_alu_s;
  logic        i_sign_s;
  logic        is_jalr_s;
  logic        mem_wait_s;
  logic        timeout_s;
  logic        unused_s;
`ifdef INT_HANDLER_EN
  logic        ie_r;
  logic        is_eret_s;
`endif

  assign op_s      = Inst[31:26];
  assign funct_s   = Inst[5:0];
  assign is_jalr_s = (op_s == OP_RTYPE) && (funct_s == FN_JALR);
`ifdef INT_HANDLER_EN
  assign is_eret_s = (op_s == OP_COP0) && (funct_s == FN_ERET);
  assign unused_s  = ^{zero, Inst[25:6]};
`else
  assign unused_s  = ^{zero, INT, Inst[25:6]};
`endif

  // A memory state is waiting when MIO_ready is low. It times out when the
  // counter has reached MEM_TIMEOUT. A ready in that same cycle still wins.
  assign mem_wait_s = ((state_r == S_IF) || (state_r == S_MRD) || (state_r == S_MWR)) && !MIO_ready;
  assign timeout_s  = mem_wait_s && (cnt_r == TIMEOUT_C);

  // Map the R-type funct field to an ALU operation.
  always_comb begin
    r_alu_ok_s = 1'b1;
    r_alu_s    = 3'd2;
    case (funct_s)
      FN_ADD:  r_alu_s = 3'd2;
      FN_SUB:  r_alu_s = 3'd6;
      FN_AND:  r_alu_s = 3'd0;
      FN_OR:   r_alu_s = 3'd1;
      FN_XOR:  r_alu_s = 3'd3;
      FN_NOR:  r_alu_s = 3'd4;
      FN_SLT:  r_alu_s = 3'd7;
      FN_SRL:  r_alu_s = 3'd5;
      default: r_alu_ok_s = 1'b0;
    endcase
  end

  // Map the I-type opcode to an ALU operation. The logical immediates are
  // zero-extended.
  always_comb begin
    i_alu_s  = 3'd2;
    i_sign_s = 1'b1;
    case (op_s)
      OP_ANDI: begin i_alu_s = 3'd0; i_sign_s = 1'b0; end
      OP_ORI:  begin i_alu_s = 3'd1; i_sign_s = 1'b0; end
      OP_XORI: begin i_alu_s = 3'd3; i_sign_s = 1'b0; end
      OP_SLTI: begin i_alu_s = 3'd7; i_sign_s = 1'b1; end
      default: begin i_alu_s = 3'd2; i_sign_s = 1'b1; end
    endcase
  end

  // Choose the execute state in ID. Unknown encodings fall back to IF as a NOP.
  always_comb begin
    id_next_s = S_IF;
    case (op_s)
      OP_RTYPE: begin
        if (r_alu_ok_s) begin
          id_next_s = S_EXR;
        end else if ((funct_s == FN_JR) || (funct_s == FN_JALR)) begin
          id_next_s = S_JR;
        end else begin
          id_next_s = S_IF;
        end
      end
      OP_LW, OP_SW:                             id_next_s = S_MADR;
      OP_BEQ, OP_BNE:                           id_next_s = S_BR;
      OP_J, OP_JAL:                             id_next_s = S_JMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: id_next_s = S_EXI;
      OP_LUI:                                   id_next_s = S_LUI;
`ifdef INT_HANDLER_EN
      OP_COP0: id_next_s = is_eret_s ? S_JR : S_IF;
`endif
      default:                                  id_next_s = S_IF;
    endcase
  end

  // Choose the state that follows an instruction's last cycle. A pending,
  // enabled interrupt diverts the FSM from IF to INT.
  always_comb begin
`ifdef INT_HANDLER_EN
    if (INT && ie_r) begin
      done_next_s = S_INT;
    end else begin
      done_next_s = S_IF;
    end
`else
    done_next_s = S_IF;
`endif
  end

  // Next-state logic for the FSM.
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_RST:  next_s = S_IF;
      S_IF: begin
        if (MIO_ready)      next_s = S_ID;
        else if (timeout_s) next_s = S_ERR;
        else                next_s = S_IF;
      end
      S_ID:   next_s = id_next_s;
      S_EXR:  next_s = S_WBA;
      S_EXI:  next_s = S_WBA;
      S_MADR: next_s = (op_s == OP_LW) ? S_MRD : S_MWR;
      S_MRD: begin
        if (MIO_ready)      next_s = S_WBM;
        else if (timeout_s) next_s = S_ERR;
        else                next_s = S_MRD;
      end
      S_MWR: begin
        if (MIO_ready)      next_s = done_next_s;
        else if (timeout_s) next_s = S_ERR;
        else                next_s = S_MWR;
      end
      S_WBA, S_WBM, S_BR, S_JMP, S_JR, S_LUI: next_s = done_next_s;
      S_ERR:  next_s = S_ERR;
`ifdef INT_HANDLER_EN
      S_INT:  next_s = S_IF;
`endif
      default: next_s = S_RST;
    endcase
  end

  // Registers for the state, the memory wait counter, the sticky error flag
  // and the interrupt-enable bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_RST;
      cnt_r     <= 8'd0;
      mem_err_r <= 1'b0;
`ifdef INT_HANDLER_EN
      ie_r      <= 1'b1;
`endif
    end else begin
      state_r <= next_s;
      // Clear the counter on every state change. A change into
      // IF/MRD/MWR therefore starts that state's wait count at zero.
      if (next_s != state_r) begin
        cnt_r <= 8'd0;
      end else if (mem_wait_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (next_s == S_ERR) begin
        mem_err_r <= 1'b1;
      end
`ifdef INT_HANDLER_EN
      if ((next_s == S_INT) && (state_r != S_INT)) begin
        ie_r <= 1'b0;
      end else if ((state_r == S_JR) && is_eret_s) begin
        ie_r <= 1'b1;
      end
`endif
    end
  end

  // Decode the control strobes from the state and the IR fields. Any strobe
  // that a state does not name stays 0.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch_ne   = 1'b0;
    PCSource    = 2'd0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALU_Control = 3'd0;
    sign        = 1'b0;
`ifdef INT_HANDLER_EN
    int_ack     = 1'b0;
    EPCWrite    = 1'b0;
    int_vector  = INT_VECTOR;
`endif
    case (state_r)
      S_IF: begin
        MemRead     = 1'b1;
        ALUSrcB     = 2'd1;
        ALU_Control = 3'd2;
        IRWrite     = MIO_ready;
        PCWrite     = MIO_ready;
      end
      S_ID: begin
        ALUSrcB     = 2'd3;
        ALU_Control = 3'd2;
      end
      S_EXR: begin
        ALUSrcA     = (funct_s == FN_SRL) ? 2'd2 : 2'd1;
        ALU_Control = r_alu_s;
      end
      S_EXI: begin
        ALUSrcA     = 2'd1;
        ALUSrcB     = 2'd2;
        ALU_Control = i_alu_s;
        sign        = i_sign_s;
      end
      S_WBA: begin
        RegWrite = 1'b1;
        RegDst   = (op_s == OP_RTYPE) ? 2'd1 : 2'd0;
      end
      S_MADR: begin
        ALUSrcA     = 2'd1;
        ALUSrcB     = 2'd2;
        ALU_Control = 3'd2;
        sign        = 1'b1;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WBM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 2'd1;
        ALU_Control = 3'd6;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        Branch_ne   = (op_s == OP_BNE);
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        if (op_s == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd3;
        end else begin
          RegWrite = 1'b0;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'd3;
        if (is_jalr_s) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd3;
        end else begin
          RegWrite = 1'b0;
        end
`ifdef INT_HANDLER_EN
        // eret returns through the rs path, with the EPC placed on int_vector.
        if (is_eret_s) begin
          int_vector = epc;
        end else begin
          int_vector = INT_VECTOR;
        end
`endif
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd2;
      end
`ifdef INT_HANDLER_EN
      S_INT: begin
        EPCWrite = 1'b1;
        int_ack  = 1'b1;
        PCWrite  = 1'b1;
        PCSource = 2'd3;
      end
`endif
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign state   = state_r;
  assign mem_err = mem_err_r;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mcpu_ctrl -- self-checking bench for mcpu_ctrl (default build)
//
// For each instruction, the reference model expands the instruction into the
// cycle-by-cycle list of states and strobes that the instruction should
// produce. The model takes the per-state actions from the state table and
// inserts the chosen memory wait cycles. The bench then drives MIO_ready to
// match this list and compares the DUT's state and strobes on every falling
// edge.
// ---------------------------------------------------------------------------
module tb_mcpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst;
  logic        zero, MIO_ready, INT;
  logic        PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite, RegWrite, sign, mem_err;
  logic [1:0]  PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [2:0]  ALU_Control;
  logic [3:0]  state;

  localparam int TO = 15;

  mcpu_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Inst(Inst), .zero(zero), .MIO_ready(MIO_ready), .INT(INT),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch_ne(Branch_ne), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALU_Control(ALU_Control), .sign(sign), .state(state), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, bne;
    logic [1:0] pcsrc;
    logic       iord, mrd, mwr, irw, rw;
    logic [1:0] rdst, m2r, srca, srcb;
    logic [2:0] alu;
    logic       sgn, err;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    ctrl_t      c;
  } step_t;

  ctrl_t obs;
  assign obs = {PCWrite, PCWriteCond, Branch_ne, PCSource, IorD, MemRead, MemWrite, IRWrite,
                RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALU_Control, sign, mem_err};

  step_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic [5:0] ops[16] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                          6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0f, 6'h3f, 6'h10};
  logic [5:0] fns[12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02,
                          6'h08, 6'h09, 6'h3f, 6'h21};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input ctrl_t c, input logic rdy);
    step_t s;
    s.st = st; s.c = c; s.rdy = rdy;
    exp_q.push_back(s);
  endtask

  // A memory state: `waits` cycles with MIO_ready low, then one cycle with it high.
  // More waits than the timeout allows give TO+1 waiting cycles followed by ERR.
  task automatic mem_phase(input logic [3:0] st, input ctrl_t cw, input ctrl_t cd,
                           input int waits, output bit died);
    ctrl_t e;
    died = 1'b0;
    for (int i = 0; i < waits && i <= TO; i++) push(st, cw, 1'b0);
    if (waits > TO) begin
      died = 1'b1;
      e = '0; e.err = 1'b1;
      for (int i = 0; i < 4; i++) push(4'd14, e, rb());
    end else begin
      push(st, cd, 1'b1);
    end
  endtask

  // Expand one instruction into its expected cycle trace.
  task automatic build(input logic [31:0] ins, input int w_if, input int w_mem);
    ctrl_t c, cd;
    bit died;
    logic [5:0] op, fn;
    int alu;
    logic sg;
    op = ins[31:26]; fn = ins[5:0];
    c = '0; c.mrd = 1'b1; c.srcb = 2'd1; c.alu = 3'd2;
    cd = c; cd.irw = 1'b1; cd.pcw = 1'b1;
    mem_phase(4'd1, c, cd, w_if, died);
    if (died) return;
    c = '0; c.srcb = 2'd3; c.alu = 3'd2;
    push(4'd2, c, rb());
    c = '0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: alu = 2;  6'h22: alu = 6;  6'h24: alu = 0;  6'h25: alu = 1;
        6'h26: alu = 3;  6'h27: alu = 4;  6'h2a: alu = 7;  6'h02: alu = 5;
        default: alu = -1;
      endcase
      if (alu >= 0) begin
        c.srca = (fn == 6'h02) ? 2'd2 : 2'd1; c.alu = 3'(alu);
        push(4'd3, c, rb());
        c = '0; c.rw = 1'b1; c.rdst = 2'd1;
        push(4'd5, c, rb());
      end else if (fn == 6'h08 || fn == 6'h09) begin
        c.pcw = 1'b1; c.pcsrc = 2'd3;
        if (fn == 6'h09) begin c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd3; end
        push(4'd12, c, rb());
      end
    end else begin
      alu = -1; sg = 1'b1;
      case (op)
        6'h08: begin alu = 2; sg = 1'b1; end
        6'h0c: begin alu = 0; sg = 1'b0; end
        6'h0d: begin alu = 1; sg = 1'b0; end
        6'h0e: begin alu = 3; sg = 1'b0; end
        6'h0a: begin alu = 7; sg = 1'b1; end
        default: alu = -1;
      endcase
      if (alu >= 0) begin
        c.srca = 2'd1; c.srcb = 2'd2; c.alu = 3'(alu); c.sgn = sg;
        push(4'd4, c, rb());
        c = '0; c.rw = 1'b1;
        push(4'd5, c, rb());
      end else if (op == 6'h23 || op == 6'h2b) begin
        c.srca = 2'd1; c.srcb = 2'd2; c.alu = 3'd2; c.sgn = 1'b1;
        push(4'd6, c, rb());
        c = '0; c.iord = 1'b1;
        if (op == 6'h23) begin
          c.mrd = 1'b1;
          mem_phase(4'd7, c, c, w_mem, died);
          if (!died) begin c = '0; c.rw = 1'b1; c.m2r = 2'd1; push(4'd8, c, rb()); end
        end else begin
          c.mwr = 1'b1;
          mem_phase(4'd9, c, c, w_mem, died);
        end
      end else if (op == 6'h04 || op == 6'h05) begin
        c.srca = 2'd1; c.alu = 3'd6; c.pcwc = 1'b1; c.pcsrc = 2'd1; c.bne = (op == 6'h05);
        push(4'd10, c, rb());
      end else if (op == 6'h02 || op == 6'h03) begin
        c.pcw = 1'b1; c.pcsrc = 2'd2;
        if (op == 6'h03) begin c.rw = 1'b1; c.rdst = 2'd2; c.m2r = 2'd3; end
        push(4'd11, c, rb());
      end else if (op == 6'h0f) begin
        c.rw = 1'b1; c.m2r = 2'd2;
        push(4'd13, c, rb());
      end
    end
  endtask

  // Play the expected trace against the DUT one clock at a time.
  task automatic run(input logic [31:0] ins);
    step_t s;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(posedge clk); #1;
      if (n == 0) Inst = ins;
      MIO_ready = s.rdy; zero = rb(); INT = rb();
      @(negedge clk);
      checks++;
      assert (state === s.st) else begin
        errors++;
        $error("FAIL state ins=%h step=%0d got=%0d exp=%0d", ins, n, state, s.st);
      end
      checks++;
      assert (obs === s.c) else begin
        errors++;
        $error("FAIL ctrl ins=%h step=%0d st=%0d got=%h exp=%h", ins, n, s.st, obs, s.c);
      end
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; MIO_ready = 1'b0; zero = 1'b0; INT = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    assert (state === 4'd0) else begin
      errors++; $error("FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    assert (obs === ctrl_t'(0)) else begin
      errors++; $error("FAIL reset_ctrl got=%h exp=0", obs);
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    Inst = 32'h0; rst = 1'b0; MIO_ready = 1'b0; zero = 1'b0; INT = 1'b0;
    do_reset();

    // Directed instructions: add, lw with 3 wait cycles, beq, bne, jal.
    build(32'h0022_1820, 0, 0); run(32'h0022_1820);
    build(32'h8C04_0008, 0, 3); run(32'h8C04_0008);
    build(32'h1000_0003, 0, 0); run(32'h1000_0003);
    build(32'h1400_0003, 0, 0); run(32'h1400_0003);
    build(32'h0C00_0010, 0, 0); run(32'h0C00_0010);
    // Ready arrives exactly at the timeout count, in IF and in MRD.
    build(32'h0022_1820, 15, 0); run(32'h0022_1820);
    build(32'h8C04_0008, 0, 15); run(32'h8C04_0008);

    // Random instruction stream.
    for (int k = 0; k < 150; k++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 15)];
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 11)];
      build(ins, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)));
      run(ins);
    end

    // IF timeout: 16 cycles without ready, then a sticky ERR.
    build(32'h0022_1820, 16, 0); run(32'h0022_1820);
    do_reset();
    // MRD timeout.
    build(32'h8C04_0008, 0, 16); run(32'h8C04_0008);
    do_reset();

    // Asynchronous reset while a store waits in MWR.
    build(32'hAC04_0008, 0, 5);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    run(32'hAC04_0008);
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (state === 4'd0) else begin
      errors++; $error("FAIL async_rst_state got=%0d exp=0", state);
    end
    checks++;
    assert (MemWrite === 1'b0 && obs === ctrl_t'(0)) else begin
      errors++; $error("FAIL async_rst_ctrl got=%h exp=0", obs);
    end
    @(negedge clk); rst = 1'b1;
    build(32'h3C01_1234, 0, 0); run(32'h3C01_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
